// File: rtl/aes_cipher_pipe.sv
// aes_cipher_pipe: fully pipelined AES-128/192/256 cipher, one round per stage,
// per-block encrypt/decrypt with valid/ready stall, tag sideband and flush.
module aes_cipher_pipe #(
    parameter int KEY_BITS = 128,
    parameter int TAG_W    = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_decrypt,
    input  logic [TAG_W-1:0]    in_tag,
    input  logic [127:0]        in_block,
    input  logic [KEY_BITS-1:0] in_key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_decrypt,
    output logic [TAG_W-1:0]    out_tag,
    output logic [127:0]        out_block
);
    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
        $error("aes_cipher_pipe: KEY_BITS must be 128, 192 or 256");
    end

    typedef logic [NR:0][127:0] sched_t;
    typedef struct packed {
        logic             v;
        logic             dec;
        logic [TAG_W-1:0] tag;
        logic [127:0]     st;
        sched_t           rk;
    } stage_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = p ^ (b[i] ? x : 8'h00);
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        r = a;
        for (int i = 0; i < 6; i++) r = gmul(gmul(r, r), a);
        return gmul(r, r);
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x, input logic inv);
        logic [7:0] y;
        y = ginv(x);
        return inv ? ginv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05)
                   : y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24], 1'b0), sbox(w[23:16], 1'b0), sbox(w[15:8], 1'b0), sbox(w[7:0], 1'b0)};
    endfunction

    // SubBytes and ShiftRows fused (they commute); inv selects the inverse pair.
    function automatic logic [127:0] sub_shift(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((inv ? c - r + 4 : c + r) % 4)+r) -: 8], inv);
        return o;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s, input logic inv);
        logic [3:0][7:0] m;
        logic [127:0]    o;
        logic [7:0]      b;
        m = inv ? 32'h0e0b0d09 : 32'h02030101;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                b = '0;
                for (int j = 0; j < 4; j++) b = b ^ gmul(s[127-8*(4*c+(r+j)%4) -: 8], m[3-j]);
                o[127-8*(4*c+r) -: 8] = b;
            end
        return o;
    endfunction

    function automatic sched_t key_exp(input logic [KEY_BITS-1:0] key);
        logic [31:0] w [NW];
        logic [31:0] t;
        logic [7:0]  rc;
        sched_t      rk;
        rc = 8'h01;
        for (int i = 0; i < NW; i++) begin
            if (i < NK) w[i] = key[KEY_BITS-1-32*i -: 32];
            else begin
                t = w[i-1];
                if (i % NK == 0) begin
                    t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = xtime(rc);
                end else if (NK > 6 && i % NK == 4) t = sub_word(t);
                w[i] = w[i-NK] ^ t;
            end
        end
        for (int r = 0; r <= NR; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

    function automatic logic [127:0] round_f(input logic [127:0] s, input logic inv,
                                             input logic last, input logic [127:0] key);
        logic [127:0] t;
        t = sub_shift(s, inv);
        return inv ? (last ? t ^ key : mix(t ^ key, 1'b1)) : ((last ? t : mix(t, 1'b0)) ^ key);
    endfunction

    stage_t s_q [NR+1];
    stage_t s_d [NR+1];
    sched_t ks;
    logic   adv;

    always_comb begin
        ks       = key_exp(in_key);
        adv      = !s_q[NR].v || out_ready;
        in_ready = adv && !flush;
        s_d      = s_q;
        if (flush) begin
            for (int k = 0; k <= NR; k++) s_d[k].v = 1'b0;
        end else if (adv) begin
            s_d[0] = '{v: in_valid, dec: in_decrypt, tag: in_tag,
                       st: in_block ^ (in_decrypt ? ks[NR] : ks[0]), rk: ks};
            for (int k = 1; k <= NR; k++) begin
                s_d[k]    = s_q[k-1];
                s_d[k].st = round_f(s_q[k-1].st, s_q[k-1].dec, k == NR,
                                    s_q[k-1].rk[s_q[k-1].dec ? NR - k : k]);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) s_q <= '{default: '0};
        else        s_q <= s_d;
    end

    assign out_valid   = s_q[NR].v;
    assign out_decrypt = s_q[NR].dec;
    assign out_tag     = s_q[NR].tag;
    assign out_block   = s_q[NR].st;
endmodule

// File: tb/tb_aes_cipher_pipe.sv
// tb_aes_cipher_pipe: scoreboard bench for aes_cipher_pipe using FIPS-197 known-answer vectors.
module tb_aes_cipher_pipe;
    typedef struct packed {
        logic [7:0]   tag;
        logic         dec;
        logic [127:0] blk;
        int           cyc;
    } ent_t;

    logic         clock, reset, flush, out_ready;
    logic         in_valid, in_ready, in_decrypt, out_valid, out_decrypt;
    logic [7:0]   in_tag, out_tag;
    logic [127:0] in_block, in_key, out_block, exp_blk;
    logic         aux_valid, rdy192, rdy256, v192, v256, d192, d256;
    logic [7:0]   t192, t256;
    logic [127:0] blk192, blk256, o192, o256, exp192, exp256;
    logic [191:0] key192;
    logic [255:0] key256;

    aes_cipher_pipe #(.KEY_BITS(128), .TAG_W(8)) dut (
        .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_decrypt(in_decrypt), .in_tag(in_tag), .in_block(in_block), .in_key(in_key),
        .out_valid(out_valid), .out_ready(out_ready), .out_decrypt(out_decrypt),
        .out_tag(out_tag), .out_block(out_block));
    aes_cipher_pipe #(.KEY_BITS(192), .TAG_W(8)) dut192 (
        .clock(clock), .reset(reset), .flush(flush), .in_valid(aux_valid), .in_ready(rdy192),
        .in_decrypt(in_decrypt), .in_tag(in_tag), .in_block(blk192), .in_key(key192),
        .out_valid(v192), .out_ready(out_ready), .out_decrypt(d192),
        .out_tag(t192), .out_block(o192));
    aes_cipher_pipe #(.KEY_BITS(256), .TAG_W(8)) dut256 (
        .clock(clock), .reset(reset), .flush(flush), .in_valid(aux_valid), .in_ready(rdy256),
        .in_decrypt(in_decrypt), .in_tag(in_tag), .in_block(blk256), .in_key(key256),
        .out_valid(v256), .out_ready(out_ready), .out_decrypt(d256),
        .out_tag(t256), .out_block(o256));

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic [127:0] vk [4], vin [4], vout [4];
    logic         vdec [4];

    ent_t q [$], q192 [$], q256 [$];
    int   n_chk, n_pass, cyc, last_lat, run, max_run;
    bit   held, acc, prev_pop;
    logic [127:0] h_blk;
    logic [7:0]   h_tag;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h (t=%0t)", nm, got, exp, $time);
    endtask

    task automatic match(input string nm, input ent_t e, input logic [7:0] tg,
                         input logic d, input logic [127:0] b);
        chk({nm, "_blk"}, b, e.blk);
        chk({nm, "_tag"}, 128'(tg), 128'(e.tag));
        chk({nm, "_dec"}, 128'(d), 128'(e.dec));
    endtask

    task automatic tick();
        ent_t e;
        bit   popped;
        #1;
        if (held) begin
            chk("hold_v", 128'(out_valid), 128'(1));
            chk("hold_blk", out_block, h_blk);
            chk("hold_tag", 128'(out_tag), 128'(h_tag));
        end
        held   = out_valid && !out_ready;
        h_blk  = out_block;
        h_tag  = out_tag;
        popped = 1'b0;
        if (out_valid && out_ready) begin
            popped = 1'b1;
            if (q.size() == 0) chk("spurious", 128'(out_valid), 128'(0));
            else begin
                e = q.pop_front();
                match("main", e, out_tag, out_decrypt, out_block);
                last_lat = cyc - e.cyc;
            end
        end
        if (v192 && out_ready) begin
            if (q192.size() == 0) chk("spurious192", 128'(v192), 128'(0));
            else begin e = q192.pop_front(); match("k192", e, t192, d192, o192); end
        end
        if (v256 && out_ready) begin
            if (q256.size() == 0) chk("spurious256", 128'(v256), 128'(0));
            else begin e = q256.pop_front(); match("k256", e, t256, d256, o256); end
        end
        run      = popped ? (prev_pop ? run + 1 : 1) : 0;
        max_run  = run > max_run ? run : max_run;
        prev_pop = popped;
        acc      = in_valid && in_ready;
        if (acc) q.push_back('{in_tag, in_decrypt, exp_blk, cyc});
        if (aux_valid && rdy192) q192.push_back('{in_tag, in_decrypt, exp192, cyc});
        if (aux_valid && rdy256) q256.push_back('{in_tag, in_decrypt, exp256, cyc});
        cyc++;
        @(negedge clock);
    endtask

    task automatic send(input int op, input logic [7:0] tg);
        in_valid   = 1'b1;
        in_key     = vk[op];
        in_decrypt = vdec[op];
        in_block   = vin[op];
        exp_blk    = vout[op];
        in_tag     = tg;
    endtask

    task automatic drain(input int max);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < max && (q.size() + q192.size() + q256.size()) != 0; i++) tick();
        chk("drain", 128'(q.size() + q192.size() + q256.size()), 128'(0));
    endtask

    initial begin
        vk  = '{K1, K1, K2, K2};
        vin = '{P1, C1, P2, C2};
        vout = '{C1, P1, C2, P2};
        vdec = '{1'b0, 1'b1, 1'b0, 1'b1};
        n_chk = 0; n_pass = 0; cyc = 0; run = 0; max_run = 0; held = 0; prev_pop = 0;
        reset = 1'b1; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b0; aux_valid = 1'b0;
        in_decrypt = 1'b0; in_tag = '0; in_block = '0; in_key = K1; exp_blk = '0;
        blk192 = P1; blk256 = P1; exp192 = '0; exp256 = '0;
        key192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
        key256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        #2 reset = 1'b0;
        #1;
        chk("rst_valid", 128'(out_valid), 128'(0));
        chk("rst_tag", 128'(out_tag), 128'(0));
        chk("rst_dec", 128'(out_decrypt), 128'(0));
        chk("rst_blk", out_block, 128'(0));
        repeat (2) @(negedge clock);
        reset = 1'b1;
        #1 chk("rst_ready", 128'(in_ready), 128'(1));
        @(negedge clock);

        // AES-128 known answer and its latency
        send(0, 8'h5a);
        tick();
        drain(30);
        chk("lat128", 128'(last_lat), 128'(11));

        // AES-192 / AES-256 encrypt then decrypt of the resulting ciphertext
        aux_valid = 1'b1;
        send(0, 8'h10);
        blk192 = P1; exp192 = C192; blk256 = P1; exp256 = C256;
        tick();
        send(1, 8'h11);
        blk192 = C192; exp192 = P1; blk256 = C256; exp256 = P1;
        tick();
        aux_valid = 1'b0;
        drain(40);

        // back-to-back alternating enc/dec, tags 0..31
        max_run = 0;
        for (int i = 0; i < 32; i++) begin
            send(i % 2, 8'(i));
            tick();
            chk("b2b_acc", 128'(acc), 128'(1));
        end
        drain(40);
        chk("b2b_run", 128'(max_run), 128'(32));

        // random backpressure, continuous offers, mixed keys and modes
        begin
            int i, g, op;
            i = 0; g = 0; op = $urandom_range(3);
            while (i < 150 && g < 3000) begin
                send(op, 8'(i));
                out_ready = 1'($urandom_range(1));
                tick();
                if (acc) begin i++; op = $urandom_range(3); end
                g++;
            end
            chk("rand_sent", 128'(i), 128'(150));
        end
        drain(200);

        // flush with 5 blocks in flight; the block offered alongside flush is refused
        for (int i = 0; i < 5; i++) begin send(i % 2, 8'hf0 + 8'(i)); tick(); end
        flush = 1'b1;
        send(0, 8'hee);
        #1 chk("flush_ready", 128'(in_ready), 128'(0));
        tick();
        flush = 1'b0;
        q.delete();
        send(0, 8'h77);
        tick();
        drain(30);
        chk("lat_flush", 128'(last_lat), 128'(11));

        // reset with blocks in flight and a stalled output
        for (int i = 0; i < 12; i++) begin send(i % 4, 8'h80 + 8'(i)); tick(); end
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 128'(out_valid), 128'(0));
        chk("mid_rst_tag", 128'(out_tag), 128'(0));
        chk("mid_rst_blk", out_block, 128'(0));
        q.delete();
        held = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1 chk("mid_rst_ready", 128'(in_ready), 128'(1));
        @(negedge clock);
        out_ready = 1'b1;
        repeat (20) tick();
        send(2, 8'h99);
        tick();
        drain(30);
        chk("lat_after_rst", 128'(last_lat), 128'(11));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
